// File: rtl/param_alu.sv
// Parameterized ALU: single-cycle ADD/AND/XOR (and SUB), multi-cycle unsigned MUL.
// Optional subtract opcode is enabled by defining PARAM_ALU_SUB_EN.
module param_alu #(
    parameter int WIDTH       = 8,
    parameter int MULT_STAGES = 3
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic [2:0]         op,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] result,
    output logic               err,
    output logic               overrun
);

    localparam int RW = 2 * WIDTH;
    localparam int CW = (MULT_STAGES > 1) ? $clog2(MULT_STAGES) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(MULT_STAGES - 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_MUL  = 1'b1;

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_MUL = 3'b100;
    localparam logic [2:0] OP_SUB = 3'b101;

    logic [0:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             ovr_q, ovr_d;
    logic [RW-1:0]    result_q, result_d;

    logic             req, ill;
    logic [RW-1:0]    ext_a, ext_b, mul_a, mul_b, prod, alu;

    always_comb begin
        req   = start && (op != OP_NOP);
        ext_a = {{WIDTH{1'b0}}, A};
        ext_b = {{WIDTH{1'b0}}, B};
        // Single-stage multiply works on the live operands; otherwise on the latched copies.
        mul_a = (MULT_STAGES == 1) ? ext_a : {{WIDTH{1'b0}}, a_q};
        mul_b = (MULT_STAGES == 1) ? ext_b : {{WIDTH{1'b0}}, b_q};
        prod  = mul_a * mul_b;

        alu = '0;
        ill = 1'b0;
        case (op)
            OP_ADD: alu = ext_a + ext_b;
            OP_AND: alu = ext_a & ext_b;
            OP_XOR: alu = ext_a ^ ext_b;
            OP_MUL: alu = prod;
`ifdef PARAM_ALU_SUB_EN
            OP_SUB: alu = ext_a - ext_b;
`else
            OP_SUB: ill = 1'b1;
`endif
            default: ill = 1'b1;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        ovr_d    = 1'b0;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    if (op == OP_MUL && MULT_STAGES > 1) begin
                        state_d = S_MUL;
                        cnt_d   = CNT_LOAD;
                        a_d     = A;
                        b_d     = B;
                    end else begin
                        done_d   = 1'b1;
                        err_d    = ill;
                        result_d = ill ? '0 : alu;
                    end
                end
            end
            default: begin
                // Requests arriving mid-multiply are dropped and flagged next cycle.
                ovr_d = req;
                if (cnt_q == CW'(1)) begin
                    state_d  = S_IDLE;
                    cnt_d    = '0;
                    done_d   = 1'b1;
                    result_d = prod;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            ovr_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            done_q   <= done_d;
            err_q    <= err_d;
            ovr_q    <= ovr_d;
            result_q <= result_d;
        end
    end

    assign busy    = (state_q == S_MUL);
    assign done    = done_q;
    assign err     = err_q;
    assign overrun = ovr_q;
    assign result  = result_q;

endmodule

// File: doc/param_alu.md
PARAM_ALU -- requirements
Module: param_alu

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, operand width in bits (legal 4..32).
REQ-002 The block SHALL have parameter MULT_STAGES, default 3, multiply latency in cycles from acceptance to done (legal 1..8).
REQ-003 The block SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 The block SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-005 The block SHALL have port A  input  WIDTH  operand A.
REQ-006 The block SHALL have port B  input  WIDTH  operand B.
REQ-007 The block SHALL have port op  input  3  opcode: 000 NOP, 001 ADD, 010 AND, 011 XOR, 100 MUL, 101 SUB (Configuration), 110/111 illegal.
REQ-008 The block SHALL have port start  input  1  request; sampled every clock edge.
REQ-009 The block SHALL have port busy  output  1  multiply in flight; new requests not accepted.
REQ-010 The block SHALL have port done  output  1  one-cycle completion pulse.
REQ-011 The block SHALL have port result  output  2*WIDTH  result of the most recent completed operation.
REQ-012 The block SHALL have port err  output  1  one-cycle pulse with done for an illegal opcode.
REQ-013 The block SHALL have port overrun  output  1  one-cycle pulse the cycle after a start is dropped.

Function
REQ-014 A request SHALL be accepted on an edge where start=1, busy=0 and op!=000; A, B and op SHALL be latched at acceptance, and later input changes SHALL NOT affect that operation.
REQ-015 start with op=000 SHALL be ignored: no done, no err, no overrun.
REQ-016 ADD SHALL produce zero-extended A+B; AND and XOR SHALL produce zero-extended bitwise results; MUL SHALL produce the full unsigned 2*WIDTH-bit product.
REQ-017 ADD, AND, XOR, SUB and illegal ops SHALL assert done on the cycle immediately after acceptance (latency 1) and SHALL NOT assert busy.
REQ-018 The state machine SHALL have states IDLE and MUL; acceptance of MUL with MULT_STAGES>1 SHALL move IDLE->MUL and load a cycle counter.
REQ-019 In MUL, busy SHALL be 1 for cycles 1..MULT_STAGES-1 after acceptance; done SHALL pulse at cycle MULT_STAGES with busy=0 and state back in IDLE.
REQ-020 A start in the done cycle SHALL be accepted (back-to-back issue, no bubble).
REQ-021 With MULT_STAGES=1, MUL SHALL behave as a single-cycle op and busy SHALL remain 0.
REQ-022 start=1 with op!=000 while busy=1 SHALL be dropped and SHALL pulse overrun on the next cycle without disturbing the in-flight multiply.
REQ-023 An illegal opcode SHALL pulse done and err together and SHALL set result to 0.
REQ-024 result SHALL update only in a done cycle and SHALL hold otherwise.

Reset
REQ-025 Asserting reset_n low SHALL immediately clear busy, done, err, overrun and result to 0, state to IDLE and the counter to 0, including mid-multiply (in-flight op discarded, no done).
REQ-026 The first request SHALL be accepted on the first rising edge with reset_n high.

Configuration
REQ-027 When macro PARAM_ALU_SUB_EN is defined, op 101 SHALL produce (A-B) modulo 2^(2*WIDTH) with latency 1.
REQ-028 When PARAM_ALU_SUB_EN is undefined, op 101 SHALL be illegal per REQ-023 and no subtractor SHALL be synthesised.

Verification
REQ-029 WIDTH=8: start ADD A=0xFF B=0x01 -> next cycle done=1, result=0x0100, busy=0.
REQ-030 WIDTH=8, MULT_STAGES=3: MUL A=0xFF B=0xFF at cycle 0 -> busy=1 cycles 1-2, done=1 with result=0xFE01 at cycle 3; ADD issued at cycle 3 -> done at cycle 4.
REQ-031 MUL in flight, start XOR at cycle 1 -> overrun=1 at cycle 2; MUL still completes at cycle 3 with correct product; no XOR done.
REQ-032 reset_n low at cycle 2 of a MUL -> all outputs 0 immediately; no done after release.
REQ-033 SUB A=0x01 B=0x02: with PARAM_ALU_SUB_EN -> result=0xFFFF, err=0; without -> done=1, err=1, result=0x0000.
REQ-034 start with op=000, then op=111 -> no response for 000; done=1, err=1, result=0 for 111.
